tim_cfg_sched: RTL

Arbitrating configuration sequencer for the dual-timer APB slave (two timer channels, 8-bit register offset space, zero-wait APB). It accepts "program timer" commands from two independent requesters and serves them round-robin. Each command becomes a fixed three-write APB sequence on the timer block: disable, load count, then enable with mode.

---
 rtl/tim_cfg_pkg.sv | 49 ++++
 rtl/tim_cfg_rr_arb.sv | 30 +++
 rtl/tim_cfg_sched.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/tim_cfg_pkg.sv
// Shared state encoding, timer register map and control-word helpers for tim_cfg_sched.
package tim_cfg_pkg;

  localparam int unsigned APB_AW = 8;
  localparam int unsigned APB_DW = 32;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_W0S  = 4'd1,
    ST_W0A  = 4'd2,
    ST_W1S  = 4'd3,
    ST_W1A  = 4'd4,
    ST_W2S  = 4'd5,
    ST_W2A  = 4'd6,
    ST_RBS  = 4'd7,
    ST_RBA  = 4'd8,
    ST_DONE = 4'd9
  } tim_state_e;

  localparam logic [APB_AW-1:0] TIM_STRIDE   = 8'h14;
  localparam logic [APB_AW-1:0] TIM_LOAD_OFS = 8'h00;
  localparam logic [APB_AW-1:0] TIM_CTRL_OFS = 8'h08;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_MODE  = 1;
  localparam int unsigned CTRL_IMASK = 2;

  // Per-command attributes captured alongside the load count.
  typedef struct packed {
    logic tim;
    logic mode;
    logic imask;
  } cmd_attr_t;

  function automatic logic [APB_DW-1:0] ctrl_word(input logic imask, input logic mode,
                                                  input logic en);
    logic [APB_DW-1:0] w;
    w             = '0;
    w[CTRL_EN]    = en;
    w[CTRL_MODE]  = mode;
    w[CTRL_IMASK] = imask;
    return w;
  endfunction

  function automatic logic [APB_AW-1:0] tim_base(input logic tim);
    return tim ? TIM_STRIDE : '0;
  endfunction

endpackage

// File: rtl/tim_cfg_rr_arb.sv
// Two-requester round-robin arbiter; on a tie the requester not granted last time wins.
module tim_cfg_rr_arb (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_valid,
  input  logic       i_update,
  output logic [1:0] o_grant
);

  logic r_last;

  always_comb begin
    o_grant = 2'b00;
    if (i_valid == 2'b11) begin
      o_grant = r_last ? 2'b01 : 2'b10;
    end else begin
      o_grant = i_valid;
    end
  end

  // Reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= 1'b1;
    end else if (i_update && (|o_grant)) begin
      r_last <= o_grant[1];
    end
  end

endmodule

// File: rtl/tim_cfg_sched.sv
// Round-robin timer configuration sequencer: each command becomes a disable/load/enable APB
// write triplet. Optional CTRL readback check is enabled by TIM_CFG_SCHED_READBACK_EN.
module tim_cfg_sched
  import tim_cfg_pkg::*;
#(
  parameter int unsigned LOAD_W = 32
) (
  input  logic                   pclk,
  input  logic                   preset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_tim,
  input  logic [1:0][LOAD_W-1:0] req_load,
  input  logic [1:0]             req_mode,
  input  logic [1:0]             req_imask,
  output logic [1:0]             done,
  output logic                   err,
  output logic [APB_AW-1:0]      paddr,
  output logic                   psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [APB_DW-1:0]      pwdata,
  input  logic [APB_DW-1:0]      prdata
);

  tim_state_e        r_state;
  tim_state_e        w_next;
  cmd_attr_t         r_attr;
  cmd_attr_t         w_attr_in;
  cmd_attr_t         w_attr;
  logic [LOAD_W-1:0] r_load;
  logic [LOAD_W-1:0] w_load_in;
  logic              r_owner;
  logic              w_owner;
  logic [1:0]        w_grant;
  logic              w_gidx;
  logic              w_idle;
  logic              w_accept;

  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [APB_AW-1:0] r_paddr;
  logic [APB_DW-1:0] r_pwdata;
  logic [1:0]        r_done;
  logic              r_err;

  logic              w_psel;
  logic              w_penable;
  logic              w_pwrite;
  logic [APB_AW-1:0] w_paddr;
  logic [APB_DW-1:0] w_pwdata;
  logic [1:0]        w_done;
  logic              w_err;

  tim_cfg_rr_arb u_arb (
    .i_clk    (pclk),
    .i_rst    (preset),
    .i_valid  (req_valid),
    .i_update (w_accept),
    .o_grant  (w_grant)
  );

  assign w_idle    = (r_state == ST_IDLE);
  assign w_gidx    = w_grant[1];
  assign w_accept  = w_idle && (|w_grant);
  assign req_ready = (w_idle && !preset) ? w_grant : 2'b00;

  assign w_attr_in = '{tim: req_tim[w_gidx], mode: req_mode[w_gidx], imask: req_imask[w_gidx]};
  assign w_load_in = req_load[w_gidx];
  // Output registers are loaded from the next state, so the accept cycle must see the new payload.
  assign w_attr    = w_accept ? w_attr_in : r_attr;
  assign w_owner   = w_accept ? w_gidx : r_owner;

`ifdef TIM_CFG_SCHED_READBACK_EN
  logic w_rb_err;
  logic w_unused_prdata;
  assign w_rb_err        = (prdata[2:0] != {r_attr.imask, r_attr.mode, 1'b1});
  assign w_unused_prdata = ^prdata[APB_DW-1:3];
`else
  logic w_unused_prdata;
  assign w_unused_prdata = ^prdata;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = (w_load_in == '0) ? ST_DONE : ST_W0S;
        end
      end
      ST_W0S:  w_next = ST_W0A;
      ST_W0A:  w_next = ST_W1S;
      ST_W1S:  w_next = ST_W1A;
      ST_W1A:  w_next = ST_W2S;
      ST_W2S:  w_next = ST_W2A;
`ifdef TIM_CFG_SCHED_READBACK_EN
      ST_W2A:  w_next = ST_RBS;
`else
      ST_W2A:  w_next = ST_DONE;
`endif
      ST_RBS:  w_next = ST_RBA;
      ST_RBA:  w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_psel    = 1'b0;
    w_penable = 1'b0;
    w_pwrite  = 1'b0;
    w_paddr   = '0;
    w_pwdata  = '0;
    w_done    = 2'b00;
    w_err     = 1'b0;
    case (w_next)
      ST_W0S, ST_W0A: begin
        w_psel   = 1'b1;
        w_pwrite = 1'b1;
        w_paddr  = tim_base(w_attr.tim) + TIM_CTRL_OFS;
        w_pwdata = ctrl_word(w_attr.imask, w_attr.mode, 1'b0);
      end
      ST_W1S, ST_W1A: begin
        w_psel   = 1'b1;
        w_pwrite = 1'b1;
        w_paddr  = tim_base(w_attr.tim) + TIM_LOAD_OFS;
        w_pwdata = APB_DW'(r_load);
      end
      ST_W2S, ST_W2A: begin
        w_psel   = 1'b1;
        w_pwrite = 1'b1;
        w_paddr  = tim_base(w_attr.tim) + TIM_CTRL_OFS;
        w_pwdata = ctrl_word(w_attr.imask, w_attr.mode, 1'b1);
      end
      ST_RBS, ST_RBA: begin
        w_psel  = 1'b1;
        w_paddr = tim_base(w_attr.tim) + TIM_CTRL_OFS;
      end
      ST_DONE: begin
        w_done = w_owner ? 2'b10 : 2'b01;
        if (r_state == ST_IDLE) begin
          w_err = 1'b1;
        end
`ifdef TIM_CFG_SCHED_READBACK_EN
        else if (r_state == ST_RBA) begin
          w_err = w_rb_err;
        end
`endif
      end
      default: ;
    endcase
    w_penable = (w_next == ST_W0A) || (w_next == ST_W1A) || (w_next == ST_W2A) ||
                (w_next == ST_RBA);
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_attr    <= '0;
      r_load    <= '0;
      r_owner   <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_done    <= 2'b00;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_attr  <= w_attr_in;
        r_load  <= w_load_in;
        r_owner <= w_gidx;
      end
      r_psel    <= w_psel;
      r_penable <= w_penable;
      r_pwrite  <= w_pwrite;
      r_paddr   <= w_paddr;
      r_pwdata  <= w_pwdata;
      r_done    <= w_done;
      r_err     <= w_err;
    end
  end

  assign psel    = r_psel;
  assign penable = r_penable;
  assign pwrite  = r_pwrite;
  assign paddr   = r_paddr;
  assign pwdata  = r_pwdata;
  assign done    = r_done;
  assign err     = r_err;

endmodule
